// File: rtl/regbank_dump_ctrl_if.sv
// Dump stream bundle: one beat per valid/ready handshake, plus an end-of-dump pulse.
interface regbank_dump_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic              dump_done;

  modport master (
    output dump_valid,
    output dump_idx,
    output dump_data,
    output dump_done,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_idx,
    input  dump_data,
    input  dump_done,
    output dump_ready
  );
endinterface

// File: rtl/regbank_dump_ctrl.sv
// Debug-dump controller for the ID-stage register bank: stalls and drains the pipe,
// borrows read port 1, streams every register out, then hands the port back.
module regbank_dump_ctrl #(
  parameter int NUM_REGS     = 32,
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_dump_req,
  input  logic [ADDR_W-1:0] i_pipe_rs,
  input  logic [ADDR_W-1:0] i_pipe_rt,
  output logic [ADDR_W-1:0] o_rd_addr_1,
  output logic [ADDR_W-1:0] o_rd_addr_2,
  input  logic [DATA_W-1:0] i_rd_data_1,
  input  logic              i_reg_write,
  input  logic [ADDR_W-1:0] i_write_register,
  input  logic [DATA_W-1:0] i_write_data,
  output logic              o_stall,
  output logic              o_busy,
  regbank_dump_ctrl_if.master dump
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    READ,
    SEND,
    DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  drain_cnt;
  logic              req_q;
  logic              req_rise;
  logic              fwd_hit;
  logic [DATA_W-1:0] read_value;

  assign req_rise = i_dump_req & ~req_q;

  // WB writes land in the bank after this read, so the in-flight value wins; r0 is hardwired.
  always_comb begin
    fwd_hit    = i_reg_write && (i_write_register == idx) && (idx != '0);
    read_value = fwd_hit ? i_write_data : i_rd_data_1;
  end

  always_comb begin
    o_rd_addr_1 = (state == READ) ? idx : i_pipe_rs;
    o_rd_addr_2 = i_pipe_rt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      idx            <= '0;
      drain_cnt      <= '0;
      req_q          <= 1'b0;
      o_stall        <= 1'b0;
      o_busy         <= 1'b0;
      dump.dump_valid <= 1'b0;
      dump.dump_done  <= 1'b0;
      dump.dump_data  <= '0;
      dump.dump_idx   <= '0;
    end else begin
      req_q          <= i_dump_req;
      dump.dump_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_rise) begin
            state     <= DRAIN;
            drain_cnt <= '0;
            o_stall   <= 1'b1;
            o_busy    <= 1'b1;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == CNT_LAST) begin
            state <= READ;
          end
        end
        READ: begin
          dump.dump_data  <= read_value;
          dump.dump_idx   <= idx;
          dump.dump_valid <= 1'b1;
          state           <= SEND;
        end
        SEND: begin
          if (dump.dump_ready) begin
            dump.dump_valid <= 1'b0;
            if (idx == IDX_LAST) begin
              state          <= DONE;
              dump.dump_done <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= READ;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          idx     <= '0;
          o_stall <= 1'b0;
          o_busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_dump_ctrl.sv
// Scoreboard bench for regbank_dump_ctrl: stimulus queues expected beats, a negedge monitor checks them.
module tb_regbank_dump_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        dump_req;
  logic [4:0]  pipe_rs;
  logic [4:0]  pipe_rt;
  logic [4:0]  rd_addr_1;
  logic [4:0]  rd_addr_2;
  logic [31:0] rd_data_1;
  logic        reg_write;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        stall;
  logic        busy;

  regbank_dump_ctrl_if #(.ADDR_W(5), .DATA_W(32)) dif ();

  regbank_dump_ctrl #(
    .NUM_REGS    (32),
    .ADDR_W      (5),
    .DATA_W      (32),
    .DRAIN_CYCLES(4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_dump_req      (dump_req),
    .i_pipe_rs       (pipe_rs),
    .i_pipe_rt       (pipe_rt),
    .o_rd_addr_1     (rd_addr_1),
    .o_rd_addr_2     (rd_addr_2),
    .i_rd_data_1     (rd_data_1),
    .i_reg_write     (reg_write),
    .i_write_register(write_register),
    .i_write_data    (write_data),
    .o_stall         (stall),
    .o_busy          (busy),
    .dump            (dif)
  );

  always #5 clk = ~clk;

  logic [31:0] bank [32];
  assign rd_data_1 = bank[rd_addr_1];

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } beat_t;

  beat_t sb[$];
  beat_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int hold_cycles = 0;
  int bp_idx  = -1;
  int bp_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] reg_val(input int k);
    return (k == 0) ? 32'h0 : 32'h1000_0000 + 32'(k);
  endfunction

  task automatic push_dump(input int fwd_idx, input logic [31:0] fwd_data);
    beat_t b;
    for (int k = 0; k < 32; k++) begin
      b.idx  = 5'(k);
      b.data = (k == fwd_idx) ? fwd_data : reg_val(k);
      sb.push_back(b);
    end
  endtask

  task automatic pulse_req();
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
  endtask

  task automatic wait_done();
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt == start) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done pulse, required one within 400 cycles");
    end else begin
      chk("done_once", 32'(done_cnt - start), 32'd1);
      chk("done_is_pulse", {31'b0, dif.dump_done}, 32'd0);
      chk("stall_released", {31'b0, stall}, 32'd0);
      chk("busy_released", {31'b0, busy}, 32'd0);
      chk("all_beats_seen", 32'(sb.size()), 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
    chk({tag, "_busy"},  {31'b0, busy},  32'd0);
    chk({tag, "_valid"}, {31'b0, dif.dump_valid}, 32'd0);
    chk({tag, "_done"},  {31'b0, dif.dump_done},  32'd0);
    chk({tag, "_data"},  dif.dump_data, 32'd0);
    chk({tag, "_idx"},   {27'b0, dif.dump_idx}, 32'd0);
  endtask

  // Sink: ready high except for a bounded backpressure window on one chosen beat.
  initial begin
    dif.dump_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (dif.dump_valid && (int'(dif.dump_idx) == bp_idx) && bp_left > 0) begin
        dif.dump_ready = 1'b0;
        bp_left--;
      end else begin
        dif.dump_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (dif.dump_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got idx %0d data %h, required no beat", dif.dump_idx, dif.dump_data);
        end else if (dif.dump_ready) begin
          mon_e = sb.pop_front();
          chk("beat_idx", {27'b0, dif.dump_idx}, {27'b0, mon_e.idx});
          chk("beat_data", dif.dump_data, mon_e.data);
        end else begin
          hold_cycles++;
          chk("hold_idx", {27'b0, dif.dump_idx}, {27'b0, sb[0].idx});
          chk("hold_data", dif.dump_data, sb[0].data);
        end
      end
      if (dif.dump_done) done_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int start_done;
    for (int k = 0; k < 32; k++) bank[k] = reg_val(k);
    reset          = 1'b0;
    dump_req       = 1'b0;
    pipe_rs        = 5'd3;
    pipe_rt        = 5'd17;
    reg_write      = 1'b0;
    write_register = 5'd0;
    write_data     = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    chk("idle_rd_addr_1", {27'b0, rd_addr_1}, 32'd3);
    chk("idle_rd_addr_2", {27'b0, rd_addr_2}, 32'd17);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Plain dump with latency checks
    push_dump(-1, 32'h0);
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    chk("stall_after_edge", {31'b0, stall}, 32'd1);
    chk("busy_after_edge", {31'b0, busy}, 32'd1);
    chk("no_valid_in_drain", {31'b0, dif.dump_valid}, 32'd0);
    n = 0;
    while (!dif.dump_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (n == 2) begin
        chk("drain_rd_addr_1", {27'b0, rd_addr_1}, 32'd3);
        chk("drain_rd_addr_2", {27'b0, rd_addr_2}, 32'd17);
      end
    end
    chk("first_valid_latency", 32'(n), 32'd5);
    wait_done();

    // Backpressure on beat 7
    repeat (2) @(posedge clk);
    #1;
    hold_cycles = 0;
    bp_idx  = 7;
    bp_left = 5;
    push_dump(-1, 32'h0);
    pulse_req();
    wait_done();
    chk("backpressure_cycles", 32'(hold_cycles), 32'd5);
    bp_idx = -1;

    // Forwarding into idx 9 during its READ cycle
    repeat (2) @(posedge clk);
    #1;
    push_dump(9, 32'hDEAD_BEEF);
    pulse_req();
    n = 0;
    while (!(stall && rd_addr_1 == 5'd9) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL read9_timeout: got no READ of idx 9, required one within 200 cycles");
    end
    reg_write      = 1'b1;
    write_register = 5'd9;
    write_data     = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    reg_write = 1'b0;
    wait_done();

    // Write aimed at r0 held for the whole dump: r0 still dumps 0
    repeat (2) @(posedge clk);
    #1;
    reg_write      = 1'b1;
    write_register = 5'd0;
    write_data     = 32'hDEAD_BEEF;
    push_dump(-1, 32'h0);
    pulse_req();
    wait_done();
    reg_write = 1'b0;

    // Level held high and retoggled mid-dump: one dump only
    repeat (2) @(posedge clk);
    #1;
    push_dump(-1, 32'h0);
    dump_req = 1'b1;
    n = 0;
    while (!dif.dump_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    pipe_rt = 5'd22;
    #1;
    chk("dump_rd_addr_2", {27'b0, rd_addr_2}, 32'd22);
    dump_req = 1'b0;
    @(posedge clk); #1;
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    @(posedge clk); #1;
    dump_req = 1'b1;
    wait_done();
    start_done = done_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("no_retrigger_busy", {31'b0, busy}, 32'd0);
    chk("no_retrigger_done", 32'(done_cnt), 32'(start_done));
    pipe_rs = 5'd12;
    #1;
    chk("idle_rd_addr_1_b", {27'b0, rd_addr_1}, 32'd12);
    dump_req = 1'b0;
    @(posedge clk); #1;
    push_dump(-1, 32'h0);
    pulse_req();
    wait_done();

    // Async reset during beat 12, then a fresh dump from idx 0
    repeat (2) @(posedge clk);
    #1;
    push_dump(-1, 32'h0);
    start_done = done_cnt;
    pulse_req();
    n = 0;
    while (!(dif.dump_valid && dif.dump_idx == 5'd12) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reached_beat12", {27'b0, dif.dump_idx}, 32'd12);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    sb.delete();
    @(posedge clk); #1;
    chk("midrst_no_done", 32'(done_cnt), 32'(start_done));
    reset = 1'b1;
    @(posedge clk); #1;
    push_dump(-1, 32'h0);
    pulse_req();
    wait_done();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regbank_dump_ctrl.md
Name: regbank_dump_ctrl

Overview:
- Debug-dump controller for the ID-stage register bank.
- On a dump request it stalls the pipeline and waits for in-flight instructions to retire.
- It then takes read port 1 away from the decode stage and streams registers 0..NUM_REGS-1 out over a valid/ready interface.
- When the stream ends, it returns the port to decode and releases the stall.

Parameters:
- NUM_REGS, 32, number of registers dumped (indices 0..NUM_REGS-1).
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- DRAIN_CYCLES, 4, cycles spent in DRAIN, measured from the first DRAIN cycle, before the first read; must be >= 1.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_dump_req  input  1  dump request; a rising edge starts a dump.
- i_pipe_rs  input  ADDR_W  decode-stage rs address.
- i_pipe_rt  input  ADDR_W  decode-stage rt address.
- o_rd_addr_1  output  ADDR_W  read register 1 address to the bank.
- o_rd_addr_2  output  ADDR_W  read register 2 address to the bank; always equal to i_pipe_rt.
- i_rd_data_1  input  DATA_W  bank read data 1; combinational read.
- i_reg_write  input  1  WB write enable, snooped.
- i_write_register  input  ADDR_W  WB destination register, snooped.
- i_write_data  input  DATA_W  WB data, snooped.
- o_stall  output  1  freezes the IF/ID/EX pipeline registers.
- o_dump_valid  output  1  dump beat valid.
- i_dump_ready  input  1  sink ready.
- o_dump_idx  output  ADDR_W  register index of the current beat.
- o_dump_data  output  DATA_W  register value of the current beat.
- o_dump_done  output  1  one-cycle pulse after the last beat is accepted.
- o_busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, active-low) values:
  - state = IDLE, idx = 0, drain counter = 0, edge-detect flop = 0.
  - o_stall = 0, o_dump_valid = 0, o_dump_done = 0, o_busy = 0.
  - o_dump_data = 0, o_dump_idx = 0.
- Request detection:
  - A rising edge is i_dump_req = 1 while the registered previous value = 0.
  - A level held high does not retrigger.
  - Edges seen in any state other than IDLE are ignored and not queued.
- IDLE:
  - o_rd_addr_1 = i_pipe_rs.
  - On a rising edge: go to DRAIN and clear the counter.
- DRAIN:
  - o_stall = 1; counter increments each cycle.
  - Advance to READ on the cycle the counter equals DRAIN_CYCLES-1. Example: DRAIN_CYCLES = 4 gives exactly 4 DRAIN cycles.
  - o_rd_addr_1 = i_pipe_rs.
- READ (1 cycle):
  - o_stall = 1, o_rd_addr_1 = idx.
  - On the next edge, latch o_dump_data <= write-first value and o_dump_idx <= idx, then go to SEND.
  - Write-first value: i_write_data if i_reg_write = 1, i_write_register == idx and idx != 0; otherwise i_rd_data_1.
- SEND:
  - o_stall = 1, o_dump_valid = 1.
  - o_dump_data and o_dump_idx are held stable until i_dump_ready = 1.
  - On a handshake:
    - If idx == NUM_REGS-1: go to DONE.
    - Otherwise: idx <= idx+1, go to READ.
  - Throughput is 1 beat per 2 cycles with ready held high.
- DONE (1 cycle):
  - o_dump_done = 1, o_stall = 1.
  - Then go to IDLE, clear idx and drop o_stall on entry to IDLE.
- Register 0:
  - Always dumped as the bank's value, which is 0.
  - The forwarding rule never applies to idx 0.
- Reset asserted mid-dump: immediate return to the reset state. No done pulse, no partial beat held.
- o_busy = (state != IDLE). The stall covers DRAIN, READ, SEND and DONE.

Test Plan:
- Reset, then a single pulse on i_dump_req with the bank preloaded so that reg k = 0x1000_0000+k and reg 0 = 0:
  - o_stall rises the cycle after the edge.
  - The first o_dump_valid appears after 4 DRAIN cycles plus 1 READ cycle.
  - 32 beats carry idx 0..31 with data 0, 0x1000_0001, …, 0x1000_001F.
  - o_dump_done pulses once, then o_stall = 0.
- Sink backpressure: i_dump_ready low for 5 cycles on beat 7:
  - valid, idx = 7 and data stay stable for the whole stall.
  - No beat is dropped or duplicated.
- Forwarding: i_reg_write = 1, i_write_register = 9, i_write_data = 0xDEAD_BEEF during the READ cycle for idx 9:
  - beat 9 carries 0xDEAD_BEEF.
  - The same write aimed at reg 0 still yields a beat-0 value of 0.
- i_dump_req held high through the whole dump and retoggled during SEND:
  - exactly one dump occurs.
  - A new rising edge after returning to IDLE starts a second dump.
- Outside a dump, o_rd_addr_1 = i_pipe_rs and o_rd_addr_2 = i_pipe_rt. During the dump o_rd_addr_2 still tracks i_pipe_rt.
- Reset deasserted-to-asserted during beat 12:
  - all outputs go to reset values asynchronously.
  - A subsequent request dumps from idx 0.
